// File: rtl/cdb_broadcast_if.sv
// FU-completion / CDB-broadcast bundle: FU results in, ready back, 3-wide broadcast out.
interface cdb_broadcast_if #(
  parameter int N_FU = 8,
  parameter int PRW  = 6,
  parameter int XLEN = 32
);
  logic [N_FU-1:0]      fu_done_valid;
  logic [N_FU*PRW-1:0]  fu_done_tag;
  logic [N_FU*XLEN-1:0] fu_done_value;
  logic [N_FU-1:0]      fu_done_ready;
  logic [2:0]           cdb_valid;
  logic [3*PRW-1:0]     cdb_tag;
  logic [3*XLEN-1:0]    cdb_value;

  modport master (
    output fu_done_valid, fu_done_tag, fu_done_value,
    input  fu_done_ready, cdb_valid, cdb_tag, cdb_value
  );

  modport slave (
    input  fu_done_valid, fu_done_tag, fu_done_value,
    output fu_done_ready, cdb_valid, cdb_tag, cdb_value
  );
endinterface

// File: rtl/cdb_broadcast.sv
// Completion buffer: one hold slot per FU, round-robin pick of up to 3 results per
// cycle onto the CDB tag/value broadcast.
module cdb_broadcast #(
  parameter int N_FU = 8,
  parameter int PRW  = 6,
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            squash,
  cdb_broadcast_if.slave  bus
);
  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;
  localparam int NSLOT = 3;

  logic [N_FU-1:0]  vld_p0;
  logic [PRW-1:0]   tag_p0 [N_FU];
  logic [XLEN-1:0]  val_p0 [N_FU];
  logic [PTR_W-1:0] rr_ptr;

  logic [N_FU-1:0]  granted;
  logic [N_FU-1:0]  take;
  logic [N_FU-1:0]  tag_nz;
  logic [NSLOT-1:0] slot_vld;
  logic [PTR_W-1:0] slot_idx [NSLOT];
  logic [PTR_W-1:0] last_idx;
  logic [PTR_W-1:0] scan_idx;
  logic [1:0]       n_hit;

  function automatic logic [PTR_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = (base + off) % N_FU;
    return s[PTR_W-1:0];
  endfunction

  // Grant: scan hold slots from rr_ptr; depends on state and squash only.
  always_comb begin
    granted  = '0;
    slot_vld = '0;
    slot_idx = '{default: '0};
    last_idx = '0;
    scan_idx = '0;
    n_hit    = '0;
    for (int k = 0; k < N_FU; k++) begin
      scan_idx = wrap_idx(int'(rr_ptr), k);
      if (!squash && vld_p0[scan_idx] && (n_hit < 2'(NSLOT))) begin
        granted[scan_idx] = 1'b1;
        slot_vld[n_hit]   = 1'b1;
        slot_idx[n_hit]   = scan_idx;
        last_idx          = scan_idx;
        n_hit             = n_hit + 2'd1;
      end
    end
  end

  always_comb begin
    bus.cdb_valid = slot_vld;
    bus.cdb_tag   = '0;
    bus.cdb_value = '0;
    for (int k = 0; k < NSLOT; k++) begin
      if (slot_vld[k]) begin
        bus.cdb_tag[k*PRW +: PRW]     = tag_p0[slot_idx[k]];
        bus.cdb_value[k*XLEN +: XLEN] = val_p0[slot_idx[k]];
      end
    end
  end

  assign bus.fu_done_ready = ~vld_p0 | granted;

  always_comb begin
    tag_nz = '0;
    for (int i = 0; i < N_FU; i++) begin
      tag_nz[i] = |bus.fu_done_tag[i*PRW +: PRW];
    end
  end

  assign take = bus.fu_done_valid & bus.fu_done_ready & {N_FU{~squash}};

  // Stage p0: hold-slot valids and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0 <= '0;
      rr_ptr <= '0;
    end else if (squash) begin
      vld_p0 <= '0;
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (take[i]) begin
          vld_p0[i] <= tag_nz[i];
        end else if (granted[i]) begin
          vld_p0[i] <= 1'b0;
        end
      end
      if (|granted) begin
        rr_ptr <= wrap_idx(int'(last_idx), 1);
      end
    end
  end

  // Stage p0 data: tag-0 results are accepted but never stored.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_FU; i++) begin
      if (take[i] && tag_nz[i]) begin
        tag_p0[i] <= bus.fu_done_tag[i*PRW +: PRW];
        val_p0[i] <= bus.fu_done_value[i*XLEN +: XLEN];
      end
    end
  end
endmodule

// File: tb/tb_cdb_broadcast.sv
// Directed bench for cdb_broadcast: single result, burst, saturation, tag 0, squash, reset.
module tb_cdb_broadcast;
  localparam int N_FU = 8;
  localparam int PRW  = 6;
  localparam int XLEN = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic squash = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  cdb_broadcast_if #(.N_FU(N_FU), .PRW(PRW), .XLEN(XLEN)) bus ();

  cdb_broadcast #(.N_FU(N_FU), .PRW(PRW), .XLEN(XLEN)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_fu();
    bus.fu_done_valid = '0;
    bus.fu_done_tag   = '0;
    bus.fu_done_value = '0;
  endtask

  task automatic set_fu(input int i, input logic [PRW-1:0] t, input logic [XLEN-1:0] v);
    bus.fu_done_valid[i]            = 1'b1;
    bus.fu_done_tag[i*PRW +: PRW]    = t;
    bus.fu_done_value[i*XLEN +: XLEN] = v;
  endtask

  task automatic do_reset();
    clear_fu();
    squash = 1'b0;
    reset  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.cdb_valid !== 3'b000) begin n_err++; $display("FAIL reset_valid got %b exp 000", bus.cdb_valid); end
    n_cmp++;
    if (bus.cdb_tag !== '0 || bus.cdb_value !== '0) begin
      n_err++; $display("FAIL reset_data got tag %h value %h exp 0", bus.cdb_tag, bus.cdb_value);
    end
    n_cmp++;
    if (bus.fu_done_ready !== 8'hFF) begin n_err++; $display("FAIL reset_ready got %b exp 11111111", bus.fu_done_ready); end
    n_cmp++;
    if (dut.rr_ptr !== 3'd0) begin n_err++; $display("FAIL reset_rr got %0d exp 0", dut.rr_ptr); end
  endtask

  task automatic test_single();
    do_reset();
    set_fu(2, 6'd5, 32'hDEAD);
    tick();
    clear_fu();
    n_cmp++;
    if (bus.cdb_valid !== 3'b001 || bus.cdb_tag !== {6'd0, 6'd0, 6'd5}) begin
      n_err++; $display("FAIL t1_slot0 got valid %b tag %h exp 001 / 5", bus.cdb_valid, bus.cdb_tag);
    end
    n_cmp++;
    if (bus.cdb_value !== {32'd0, 32'd0, 32'hDEAD}) begin
      n_err++; $display("FAIL t1_value got %h exp DEAD", bus.cdb_value);
    end
    tick();
    n_cmp++;
    if (bus.cdb_valid !== 3'b000) begin n_err++; $display("FAIL t1_after got %b exp 000", bus.cdb_valid); end
  endtask

  task automatic test_burst();
    do_reset();
    for (int i = 0; i < 5; i++) set_fu(i, 6'(i + 1), 32'h100 + i);
    tick();
    clear_fu();
    n_cmp++;
    if (bus.cdb_valid !== 3'b111 || bus.cdb_tag !== {6'd3, 6'd2, 6'd1}) begin
      n_err++; $display("FAIL t2_first got valid %b tag %h exp 111 / 3,2,1", bus.cdb_valid, bus.cdb_tag);
    end
    n_cmp++;
    if (bus.cdb_value !== {32'h102, 32'h101, 32'h100}) begin
      n_err++; $display("FAIL t2_first_val got %h exp 102,101,100", bus.cdb_value);
    end
    n_cmp++;
    if (bus.fu_done_ready !== 8'b1110_0111) begin
      n_err++; $display("FAIL t2_ready got %b exp 11100111", bus.fu_done_ready);
    end
    tick();
    n_cmp++;
    if (bus.cdb_valid !== 3'b011 || bus.cdb_tag !== {6'd0, 6'd5, 6'd4}) begin
      n_err++; $display("FAIL t2_second got valid %b tag %h exp 011 / 0,5,4", bus.cdb_valid, bus.cdb_tag);
    end
    n_cmp++;
    if (bus.cdb_value !== {32'd0, 32'h104, 32'h103}) begin
      n_err++; $display("FAIL t2_second_val got %h exp 0,104,103", bus.cdb_value);
    end
    tick();
    n_cmp++;
    if (dut.rr_ptr !== 3'd5 || bus.cdb_valid !== 3'b000) begin
      n_err++; $display("FAIL t2_end got rr %0d valid %b exp 5 / 000", dut.rr_ptr, bus.cdb_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3*PRW-1:0]  exp_tag [4];
    logic [3*XLEN-1:0] exp_val [4];
    logic [N_FU-1:0]   exp_rdy [4];
    exp_tag[0] = {6'd10, 6'd9,  6'd8};  exp_rdy[0] = 8'b0000_0111;
    exp_tag[1] = {6'd13, 6'd12, 6'd11}; exp_rdy[1] = 8'b0011_1000;
    exp_tag[2] = {6'd8,  6'd15, 6'd14}; exp_rdy[2] = 8'b1100_0001;
    exp_tag[3] = {6'd11, 6'd10, 6'd9};  exp_rdy[3] = 8'b0000_1110;
    exp_val[0] = {32'h1002, 32'h1001, 32'h1000};
    exp_val[1] = {32'h1005, 32'h1004, 32'h1003};
    exp_val[2] = {32'h1000, 32'h1007, 32'h1006};
    exp_val[3] = {32'h1003, 32'h1002, 32'h1001};
    do_reset();
    for (int i = 0; i < N_FU; i++) set_fu(i, 6'(8 + i), 32'h1000 + i);
    tick();
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (bus.cdb_valid !== 3'b111 || bus.cdb_tag !== exp_tag[c]) begin
        n_err++; $display("FAIL t3_tags[%0d] got valid %b tag %h exp 111 / %h", c, bus.cdb_valid, bus.cdb_tag, exp_tag[c]);
      end
      n_cmp++;
      if (bus.cdb_value !== exp_val[c]) begin
        n_err++; $display("FAIL t3_vals[%0d] got %h exp %h", c, bus.cdb_value, exp_val[c]);
      end
      n_cmp++;
      if (bus.fu_done_ready !== exp_rdy[c]) begin
        n_err++; $display("FAIL t3_ready[%0d] got %b exp %b", c, bus.fu_done_ready, exp_rdy[c]);
      end
      tick();
    end
    clear_fu();
  endtask

  task automatic test_tag_zero();
    do_reset();
    set_fu(1, 6'd0, 32'd77);
    #1;
    n_cmp++;
    if (bus.fu_done_ready[1] !== 1'b1) begin n_err++; $display("FAIL t4_ready got %b exp 1", bus.fu_done_ready[1]); end
    tick();
    clear_fu();
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (bus.cdb_valid !== 3'b000 || dut.vld_p0[1] !== 1'b0 || bus.fu_done_ready[1] !== 1'b1) begin
        n_err++; $display("FAIL t4_drop[%0d] got valid %b hv1 %b rdy1 %b exp 000 / 0 / 1",
                          c, bus.cdb_valid, dut.vld_p0[1], bus.fu_done_ready[1]);
      end
      tick();
    end
  endtask

  task automatic test_squash();
    do_reset();
    for (int i = 0; i < 6; i++) set_fu(i, 6'(i + 1), 32'h200 + i);
    tick();
    clear_fu();
    squash = 1'b1;
    set_fu(3, 6'd9, 32'h999);
    set_fu(6, 6'd10, 32'hAAA);
    #1;
    n_cmp++;
    if (bus.cdb_valid !== 3'b000 || bus.cdb_tag !== '0) begin
      n_err++; $display("FAIL t5_squash_cycle got valid %b tag %h exp 000 / 0", bus.cdb_valid, bus.cdb_tag);
    end
    n_cmp++;
    if (bus.fu_done_ready !== 8'b1100_0000) begin
      n_err++; $display("FAIL t5_ready got %b exp 11000000", bus.fu_done_ready);
    end
    tick();
    squash = 1'b0;
    clear_fu();
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (bus.cdb_valid !== 3'b000 || dut.vld_p0 !== 8'h00) begin
        n_err++; $display("FAIL t5_after[%0d] got valid %b hv %b exp 000 / 0", c, bus.cdb_valid, dut.vld_p0);
      end
      tick();
    end
    n_cmp++;
    if (dut.rr_ptr !== 3'd0) begin n_err++; $display("FAIL t5_rr got %0d exp 0", dut.rr_ptr); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) set_fu(i, 6'(i + 1), 32'h300 + i);
    tick();
    clear_fu();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.cdb_tag !== {6'd3, 6'd2, 6'd1}) begin
      n_err++; $display("FAIL t6_pre got tag %h exp 3,2,1", bus.cdb_tag);
    end
    tick();
    reset = 1'b0;
    n_cmp++;
    if (bus.cdb_valid !== 3'b000 || bus.fu_done_ready !== 8'hFF || dut.rr_ptr !== 3'd0) begin
      n_err++; $display("FAIL t6_reset got valid %b ready %b rr %0d exp 000 / FF / 0",
                        bus.cdb_valid, bus.fu_done_ready, dut.rr_ptr);
    end
    set_fu(7, 6'd33, 32'hCAFE);
    tick();
    clear_fu();
    n_cmp++;
    if (bus.cdb_valid !== 3'b001 || bus.cdb_tag !== {6'd0, 6'd0, 6'd33} ||
        bus.cdb_value !== {32'd0, 32'd0, 32'hCAFE}) begin
      n_err++; $display("FAIL t6_new got valid %b tag %h value %h exp 001 / 33 / CAFE",
                        bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    end
    tick();
    n_cmp++;
    if (bus.cdb_valid !== 3'b000 || dut.rr_ptr !== 3'd0) begin
      n_err++; $display("FAIL t6_end got valid %b rr %0d exp 000 / 0", bus.cdb_valid, dut.rr_ptr);
    end
  endtask

  initial begin
    clear_fu();
    test_reset();
    test_single();
    test_burst();
    test_back_to_back();
    test_tag_zero();
    test_squash();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
